// File: rtl/ball_motion_ctrl_pkg.sv
// ball_motion_ctrl_pkg: shared FSM/direction encodings, screen constants and NES button indices.
// Optional build macro BALL_WRAP_EN (used by the axis stepper) switches edge clamping to wrapping.
package ball_motion_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SPEED, ST_MOVE} state_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_POS, DIR_NEG} dir_e;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BALL_SIZE = 16;
  localparam int NES_BUTTON_A = 0;
  localparam int NES_BUTTON_B = 1;
  localparam int NES_BUTTON_SELECT = 2;
  localparam int NES_BUTTON_START = 3;
  localparam int NES_BUTTON_UP = 4;
  localparam int NES_BUTTON_DOWN = 5;
  localparam int NES_BUTTON_LEFT = 6;
  localparam int NES_BUTTON_RIGHT = 7;
  typedef struct packed {
    logic start;
    logic up;
    logic down;
    logic left;
    logic right;
  } pad_t;
  function automatic dir_e dir_of(input logic neg, input logic pos);
    return (neg == pos) ? DIR_NONE : pos ? DIR_POS : DIR_NEG;
  endfunction
endpackage

// File: rtl/ball_motion_ctrl_axis_stepper.sv
// ball_motion_ctrl_axis_stepper: speed/acceleration and position state for one screen axis.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_neg/i_pos direction buttons;
//   i_speed_en speed-update cycle; i_move_en position-update cycle; i_recentre START override;
//   i_axis_max largest legal position; o_pos position; o_speed current speed.
// Macro BALL_WRAP_EN: positions wrap around the axis instead of clamping at the edges.
module ball_motion_ctrl_axis_stepper
  import ball_motion_ctrl_pkg::*;
#(
  parameter int MAX_SPEED = 7,
  parameter int ACCEL_FRAMES = 4,
  parameter logic [9:0] START_POS = 10'd0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_neg,
  input  logic       i_pos,
  input  logic       i_speed_en,
  input  logic       i_move_en,
  input  logic       i_recentre,
  input  logic [9:0] i_axis_max,
  output logic [9:0] o_pos,
  output logic [3:0] o_speed
);
  localparam int CW = ACCEL_FRAMES > 1 ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_FRAMES - 1);
  dir_e dir_q, dir_d, new_dir;
  logic [3:0] speed_q, speed_d, speed_up;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] pos_q, pos_d, pos_up, pos_dn;
  logic [10:0] up, lim;
  logic under, restart;
  always_comb begin
    new_dir = dir_of(i_neg, i_pos);
    up = {1'b0, pos_q} + {7'd0, speed_q};
    lim = {1'b0, i_axis_max};
    under = pos_q < {6'd0, speed_q};
`ifdef BALL_WRAP_EN
    pos_up = up > lim ? 10'(up - lim - 11'd1) : pos_q + {6'd0, speed_q};
    pos_dn = under ? 10'(lim + 11'd1 + {1'b0, pos_q} - {7'd0, speed_q}) : pos_q - {6'd0, speed_q};
`else
    pos_up = up > lim ? i_axis_max : pos_q + {6'd0, speed_q};
    pos_dn = under ? '0 : pos_q - {6'd0, speed_q};
`endif
    speed_up = speed_q == SPD_MAX ? SPD_MAX : speed_q + 4'd1;
    // a released or reversed direction restarts the acceleration ramp
    restart = new_dir == DIR_NONE || new_dir != dir_q;
    dir_d = i_speed_en ? new_dir : dir_q;
    speed_d = !i_speed_en ? speed_q :
              new_dir == DIR_NONE ? '0 :
              new_dir != dir_q ? 4'd1 :
              cnt_q == CNT_LAST ? speed_up : speed_q;
    cnt_d = !i_speed_en ? cnt_q : (restart || cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    pos_d = !i_move_en ? pos_q :
            i_recentre ? START_POS :
            dir_q == DIR_POS ? pos_up :
            dir_q == DIR_NEG ? pos_dn : pos_q;
    if (i_move_en && i_recentre) begin
      speed_d = '0;
      cnt_d = '0;
      dir_d = DIR_NONE;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir_q <= DIR_NONE;
      speed_q <= '0;
      cnt_q <= '0;
      pos_q <= START_POS;
    end else begin
      dir_q <= dir_d;
      speed_q <= speed_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end
  assign o_pos = pos_q;
  assign o_speed = speed_q;
endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame ball position controller driven by NES buttons and a vblank strobe.
// Ports: i_clk clock; i_rst_n async active-low reset; i_frame_strobe vblank pulse;
//   i_buttons NES button byte (1=pressed); o_ball_x/o_ball_y top-left ball position;
//   o_moving either axis speed nonzero; o_update_done pulse when the position registers update.
// Macro BALL_WRAP_EN: screen edges wrap instead of clamping (no port or latency change).
module ball_motion_ctrl
  import ball_motion_ctrl_pkg::*;
#(
  parameter int MAX_SPEED = 7,
  parameter int ACCEL_FRAMES = 4,
  parameter int START_X = 312,
  parameter int START_Y = 232
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_strobe,
  input  logic [7:0] i_buttons,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic       o_moving,
  output logic       o_update_done
);
  localparam logic [9:0] XMAX = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] YMAX = 10'(V_ACTIVE - BALL_SIZE);
  state_e state_q, state_d;
  pad_t pad_q, pad_d;
  logic done_q, done_d, take;
  logic [3:0] speed_x, speed_y;
  logic unused_btns;
  assign unused_btns = ^{i_buttons[NES_BUTTON_A], i_buttons[NES_BUTTON_B], i_buttons[NES_BUTTON_SELECT]};
  always_comb begin
    // strobes outside IDLE are dropped, never queued
    take = state_q == ST_IDLE && i_frame_strobe;
    state_d = take ? ST_SPEED : state_q == ST_SPEED ? ST_MOVE : ST_IDLE;
    pad_d = take ? '{start: i_buttons[NES_BUTTON_START], up: i_buttons[NES_BUTTON_UP],
                     down: i_buttons[NES_BUTTON_DOWN], left: i_buttons[NES_BUTTON_LEFT],
                     right: i_buttons[NES_BUTTON_RIGHT]} : pad_q;
    done_d = state_q == ST_MOVE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pad_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q <= pad_d;
      done_q <= done_d;
    end
  end
  ball_motion_ctrl_axis_stepper #(
    .MAX_SPEED(MAX_SPEED), .ACCEL_FRAMES(ACCEL_FRAMES), .START_POS(10'(START_X))
  ) u_x (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_neg(pad_q.left), .i_pos(pad_q.right),
    .i_speed_en(state_q == ST_SPEED), .i_move_en(state_q == ST_MOVE), .i_recentre(pad_q.start),
    .i_axis_max(XMAX), .o_pos(o_ball_x), .o_speed(speed_x)
  );
  ball_motion_ctrl_axis_stepper #(
    .MAX_SPEED(MAX_SPEED), .ACCEL_FRAMES(ACCEL_FRAMES), .START_POS(10'(START_Y))
  ) u_y (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_neg(pad_q.up), .i_pos(pad_q.down),
    .i_speed_en(state_q == ST_SPEED), .i_move_en(state_q == ST_MOVE), .i_recentre(pad_q.start),
    .i_axis_max(YMAX), .o_pos(o_ball_y), .o_speed(speed_y)
  );
  assign o_moving = |{speed_x, speed_y};
  assign o_update_done = done_q;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: directed frames against a per-frame behavioural model of ball motion.
module tb_ball_motion_ctrl;
  localparam logic [7:0] B_NONE = 8'h00, B_START = 8'h08, B_UP = 8'h10, B_DOWN = 8'h20,
                         B_LEFT = 8'h40, B_RIGHT = 8'h80;
  localparam int MAXP [2] = '{624, 464};
  localparam int STARTP [2] = '{312, 232};
  logic clk = 0, rst_n = 0, strobe = 0;
  logic [7:0] buttons = 0;
  logic [9:0] o_ball_x, o_ball_y;
  logic o_moving, o_update_done;
  int checks = 0, failures = 0, done_cnt = 0;
  bit chk_en = 0;
  int mpos [2], mspd [2], mcnt [2], mdir [2];
  bit exp_moving, exp_done;
  ball_motion_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_strobe(strobe), .i_buttons(buttons),
    .o_ball_x(o_ball_x), .o_ball_y(o_ball_y), .o_moving(o_moving), .o_update_done(o_update_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("x", 32'(o_ball_x), 32'(mpos[0]));
    check("y", 32'(o_ball_y), 32'(mpos[1]));
    check("moving", 32'(o_moving), 32'(exp_moving));
    check("done", 32'(o_update_done), 32'(exp_done));
    if (o_update_done) done_cnt++;
  end
  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      mpos[a] = STARTP[a];
      mspd[a] = 0;
      mcnt[a] = 0;
      mdir[a] = 0;
    end
    exp_moving = 0;
    exp_done = 0;
  endtask
  function automatic int want_dir(input logic [7:0] b, input int a);
    logic n, p;
    n = b[a == 0 ? 6 : 4];
    p = b[a == 0 ? 7 : 5];
    return (n == p) ? 0 : p ? 1 : -1;
  endfunction
  task automatic model_speed(input logic [7:0] b);
    for (int a = 0; a < 2; a++) begin
      int d;
      d = want_dir(b, a);
      if (d == 0) begin mspd[a] = 0; mcnt[a] = 0; end
      else if (d != mdir[a]) begin mspd[a] = 1; mcnt[a] = 0; end
      else if (mcnt[a] == 3) begin mspd[a] = (mspd[a] + 1 > 7) ? 7 : mspd[a] + 1; mcnt[a] = 0; end
      else mcnt[a]++;
      mdir[a] = d;
    end
    exp_moving = mspd[0] != 0 || mspd[1] != 0;
  endtask
  task automatic model_move(input logic [7:0] b);
    if (b[3]) begin
      model_reset();
      return;
    end
    for (int a = 0; a < 2; a++) begin
      int np;
      np = mpos[a] + mdir[a] * mspd[a];
`ifdef BALL_WRAP_EN
      if (np > MAXP[a]) np -= MAXP[a] + 1;
      if (np < 0) np += MAXP[a] + 1;
`else
      if (np > MAXP[a]) np = MAXP[a];
      if (np < 0) np = 0;
`endif
      mpos[a] = np;
    end
  endtask
  task automatic frame(input logic [7:0] b, input bit dbl);
    @(negedge clk);
    buttons = b;
    strobe = 1;
    @(posedge clk);
    if (!dbl) #1 strobe = 0;
    @(posedge clk);
    model_speed(b);
    #1 strobe = 0;
    @(posedge clk);
    model_move(b);
    exp_done = 1;
    @(posedge clk);
    exp_done = 0;
    repeat (2) @(posedge clk);
  endtask
  task automatic frames(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) frame(b, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    #1 chk_en = 1;
    #20 rst_n = 1;
    check("reset_x", 32'(o_ball_x), 312);
    check("reset_y", 32'(o_ball_y), 232);
    done_cnt = 0;
    frames(B_NONE, 3);
    check("idle_done_pulses", 32'(done_cnt), 3);
    check("idle_x", 32'(o_ball_x), 312);
    frames(B_RIGHT, 9);
    check("right9_x", 32'(o_ball_x), 327);
`ifndef BALL_WRAP_EN
    frames(B_LEFT, 60);
    check("left_clamp_x", 32'(o_ball_x), 0);
    frames(B_RIGHT | B_DOWN, 110);
    check("right_clamp_x", 32'(o_ball_x), 624);
    check("down_clamp_y", 32'(o_ball_y), 464);
`else
    frames(B_LEFT, 60);
    frames(B_RIGHT | B_DOWN, 110);
`endif
    frame(B_START | B_RIGHT, 0);
    check("start_x", 32'(o_ball_x), 312);
    check("start_y", 32'(o_ball_y), 232);
    check("start_moving", 32'(o_moving), 0);
    frames(B_RIGHT, 9);
    frame(B_LEFT | B_RIGHT | B_DOWN, 0);
    check("both_x", 32'(o_ball_x), 327);
    check("both_y", 32'(o_ball_y), 233);
    check("both_moving", 32'(o_moving), 1);
    frames(B_UP | B_LEFT, 5);
    done_cnt = 0;
    frame(B_RIGHT, 1);
    check("double_strobe_pulses", 32'(done_cnt), 1);
    @(negedge clk);
    buttons = B_RIGHT | B_UP;
    strobe = 1;
    @(posedge clk);
    #1 strobe = 0;
    @(posedge clk);
    model_speed(buttons);
    #2 rst_n = 0;
    model_reset();
    #1;
    check("midreset_x", 32'(o_ball_x), 312);
    check("midreset_y", 32'(o_ball_y), 232);
    check("midreset_moving", 32'(o_moving), 0);
    check("midreset_done", 32'(o_update_done), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    frames(B_DOWN, 2);
    check("post_reset_y", 32'(o_ball_y), 234);
    @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
